mix_sequencer: RTL and testbench

Instruction sequencer for the MIX core. Owns the program counter and the single synchronous memory port, and steps each instruction through fetch, decode, effective-address and memory phases. It emits one-cycle strobes that tell the register/field datapath when to load or merge-store. It replaces ad-hoc fetch/nop pulse logic with one explicit state machine.

---
 rtl/mix_pkg.sv | 66 ++++++
 rtl/mix_sequencer_if.sv | 33 +++
 rtl/mix_ea.sv | 36 +++
 rtl/mix_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mix_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mix_pkg
//  Description : Shared widths, instruction field positions, opcode constants
//                and sequencer state encoding for the MIX instruction
//                sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package mix_pkg;

    // Memory address width (4096 words) and MIX word width (sign + 5 bytes)
    localparam int ADDR_W   = 12;
    localparam int WORD_W   = 31;

    // Sign-magnitude index register: {sign, 12-bit magnitude}
    localparam int c_IDX_W  = 13;
    // Magnitude width of the A field
    localparam int c_MAG_W  = 12;
    // Internal signed effective-address width; wide enough for +/-8190
    localparam int c_EA_W   = 14;

    // Instruction field positions within a fetched word
    localparam int c_C_LSB    = 0;
    localparam int c_F_LSB    = 6;
    localparam int c_I_LSB    = 12;
    localparam int c_A_LSB    = 18;
    localparam int c_SIGN_BIT = 30;

    // Opcode (C field) values
    localparam logic [5:0] c_OP_NOP  = 6'd0;
    localparam logic [5:0] c_OP_ADD  = 6'd1;
    localparam logic [5:0] c_OP_HLT  = 6'd5;
    localparam logic [5:0] c_OP_LDA  = 6'd8;
    localparam logic [5:0] c_OP_LDXN = 6'd23;
    localparam logic [5:0] c_OP_STA  = 6'd24;
    localparam logic [5:0] c_OP_STZ  = 6'd33;
    localparam logic [5:0] c_OP_JMP  = 6'd39;

    // Field values that qualify HLT (C=5) and JMP (C=39)
    localparam logic [5:0] c_F_HLT   = 6'd2;
    localparam logic [5:0] c_F_JMP   = 6'd0;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ADDR   = 3'd3,
        S_READ   = 3'd4,
        S_LOAD   = 3'd5,
        S_WRITE  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // ADD and the LD*/LD*N family read an operand and hand it to the datapath
    function automatic logic is_load_op(input logic [5:0] c);
        return (c == c_OP_ADD) || ((c >= c_OP_LDA) && (c <= c_OP_LDXN));
    endfunction

    // ST*, STJ and STZ read the target word and merge a field back into it
    function automatic logic is_store_op(input logic [5:0] c);
        return (c >= c_OP_STA) && (c <= c_OP_STZ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mix_sequencer_if
//  Description : Memory port and datapath-control bundle between the MIX
//                sequencer (master) and the RAM / register datapath (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mix_sequencer_if;
    import mix_pkg::*;

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_re;
    logic               mem_we;
    logic [WORD_W-1:0]  mem_rdata;
    logic [c_IDX_W-1:0] index_val;
    logic [2:0]         idx_sel;
    logic [5:0]         ir_c;
    logic [5:0]         ir_f;
    logic               ld_strobe;
    logic               st_strobe;

    modport master (
        output mem_addr, mem_re, mem_we, idx_sel, ir_c, ir_f, ld_strobe, st_strobe,
        input  mem_rdata, index_val
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, idx_sel, ir_c, ir_f, ld_strobe, st_strobe,
        output mem_rdata, index_val
    );

endinterface
`default_nettype wire

// File: rtl/mix_ea.sv
`default_nettype none
// ============================================================================
//  Module      : mix_ea
//  Description : Combinational effective-address adder. Adds the
//                sign-magnitude A field and index register, reports the low
//                12 bits and whether the result lies outside 0..4095.
//  Revision    : 1.0  initial release
// ============================================================================
module mix_ea
    import mix_pkg::*;
(
    input  logic               i_a_sign,
    input  logic [c_MAG_W-1:0] i_a_mag,
    input  logic               i_idx_en,
    input  logic [c_IDX_W-1:0] i_index_val,
    output logic [ADDR_W-1:0]  o_ea,
    output logic               o_oor
);

    logic [c_EA_W-1:0] w_a;
    logic [c_EA_W-1:0] w_x;
    logic [c_EA_W-1:0] w_sum;

    // Negating a zero magnitude yields zero, so -0 and +0 behave identically
    assign w_a   = i_a_sign ? (c_EA_W'(0) - {2'b00, i_a_mag}) : {2'b00, i_a_mag};
    assign w_x   = !i_idx_en               ? c_EA_W'(0) :
                   i_index_val[c_IDX_W-1]  ? (c_EA_W'(0) - {2'b00, i_index_val[c_MAG_W-1:0]}) :
                                             {2'b00, i_index_val[c_MAG_W-1:0]};
    assign w_sum = w_a + w_x;

    // |sum| <= 8190, so bit 13 marks negative and bit 12 marks > 4095
    assign o_oor = w_sum[c_EA_W-1] | w_sum[c_EA_W-2];
    assign o_ea  = w_sum[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mix_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mix_sequencer
//  Description : MIX instruction sequencer. Owns the program counter and the
//                single synchronous memory port; walks each instruction
//                through fetch, decode, effective-address and memory phases
//                and issues one-cycle load / merge-store strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module mix_sequencer
    import mix_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    mix_sequencer_if.master   bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fault
);

    state_t             r_state_q;
    state_t             w_state_d;
    logic [ADDR_W-1:0]  r_pc_q;
    logic [ADDR_W-1:0]  w_pc_d;
    logic [ADDR_W-1:0]  r_ea_q;
    logic [ADDR_W-1:0]  w_ea_d;
    logic               r_fault_q;
    logic               w_fault_d;
    logic [WORD_W-1:0]  r_ir_q;
    logic [WORD_W-1:0]  w_ir_d;

    logic [5:0]         w_c;
    logic [5:0]         w_f;
    logic [2:0]         w_i;
    logic               w_a_sign;
    logic [c_MAG_W-1:0] w_a_mag;
    logic               w_idx_en;
    logic [ADDR_W-1:0]  w_ea;
    logic               w_ea_oor;
    logic               w_unused_ir;

    // Fields of the latched instruction word
    assign w_c         = r_ir_q[c_C_LSB +: 6];
    assign w_f         = r_ir_q[c_F_LSB +: 6];
    assign w_i         = r_ir_q[c_I_LSB +: 3];
    assign w_a_sign    = r_ir_q[c_SIGN_BIT];
    assign w_a_mag     = r_ir_q[c_A_LSB +: c_MAG_W];
    // Bits 17:15 sit between I and A and carry no meaning here
    assign w_unused_ir = ^r_ir_q[17:15];

    // I = 0 means unindexed and I = 7 is not an index register
    assign w_idx_en    = (w_i != 3'd0) && (w_i != 3'd7);

    mix_ea u_ea (
        .i_a_sign    (w_a_sign),
        .i_a_mag     (w_a_mag),
        .i_idx_en    (w_idx_en),
        .i_index_val (bus.index_val),
        .o_ea        (w_ea),
        .o_oor       (w_ea_oor)
    );

    // State, pc, instruction, EA and fault registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= S_IDLE;
            r_pc_q    <= '0;
            r_ea_q    <= '0;
            r_fault_q <= 1'b0;
            r_ir_q    <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_ea_q    <= w_ea_d;
            r_fault_q <= w_fault_d;
            r_ir_q    <= w_ir_d;
        end
    end

    // Next-state and register updates for each instruction phase
    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_ea_d    = r_ea_q;
        w_fault_d = r_fault_q;
        w_ir_d    = r_ir_q;
        case (r_state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_pc_d    = start_pc;
                    w_fault_d = 1'b0;
                    w_state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_d = S_DECODE;
            end
            S_DECODE: begin
                w_ir_d    = bus.mem_rdata;
                w_state_d = S_ADDR;
            end
            S_ADDR: begin
                // EA is captured here because index_val is only valid now
                w_ea_d = w_ea;
                if (w_c == c_OP_NOP) begin
                    w_pc_d    = r_pc_q + ADDR_W'(1);
                    w_state_d = S_FETCH;
                end else if ((w_c == c_OP_HLT) && (w_f == c_F_HLT)) begin
                    w_state_d = S_HALT;
                end else if ((w_c == c_OP_JMP) && (w_f == c_F_JMP)) begin
                    if (w_ea_oor) begin
                        w_fault_d = 1'b1;
                        w_state_d = S_HALT;
                    end else begin
                        w_pc_d    = w_ea;
                        w_state_d = S_FETCH;
                    end
                end else if (is_load_op(w_c) || is_store_op(w_c)) begin
                    if (w_ea_oor) begin
                        w_fault_d = 1'b1;
                        w_state_d = S_HALT;
                    end else begin
                        w_state_d = S_READ;
                    end
                end else begin
                    w_fault_d = 1'b1;
                    w_state_d = S_HALT;
                end
            end
            S_READ: begin
                w_state_d = is_store_op(w_c) ? S_WRITE : S_LOAD;
            end
            S_LOAD, S_WRITE: begin
                w_pc_d    = r_pc_q + ADDR_W'(1);
                w_state_d = S_FETCH;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Memory port and strobes decoded purely from the registered state
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.ld_strobe = 1'b0;
        bus.st_strobe = 1'b0;
        case (r_state_q)
            S_FETCH: begin
                bus.mem_addr = r_pc_q;
                bus.mem_re   = 1'b1;
            end
            S_READ: begin
                bus.mem_addr = r_ea_q;
                bus.mem_re   = 1'b1;
            end
            S_LOAD: begin
                bus.ld_strobe = 1'b1;
            end
            S_WRITE: begin
                bus.mem_addr  = r_ea_q;
                bus.mem_we    = 1'b1;
                bus.st_strobe = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.idx_sel = w_i;
    assign bus.ir_c    = w_c;
    assign bus.ir_f    = w_f;
    assign pc          = r_pc_q;
    assign halted      = (r_state_q == S_HALT);
    assign fault       = r_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mix_sequencer
//  Description : Scoreboard testbench for mix_sequencer. Directed programs
//                push expected memory/strobe events; a monitor compares each
//                DUT event (kind, address, cycle) against the queue head.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mix_sequencer;
    import mix_pkg::*;

    localparam logic [1:0] c_K_RE  = 2'd0;
    localparam logic [1:0] c_K_WE  = 2'd1;
    localparam logic [1:0] c_K_LD  = 2'd2;
    localparam logic [1:0] c_K_BAD = 2'd3;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              fault;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t              q[$];
    exp_t              m_exp;
    logic [1:0]        m_kind;
    logic [WORD_W-1:0] mem [0:4095];
    logic [WORD_W-1:0] r_rdata = '0;
    logic [12:0]       ireg [0:7];

    mix_sequencer_if bus ();

    mix_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .start_pc (start_pc),
        .bus      (bus),
        .pc       (pc),
        .halted   (halted),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM model
    always @(posedge clk) begin
        if (bus.mem_re) r_rdata <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = r_rdata;

    // Index registers return whatever idx_sel selects, including 0 and 7,
    // so the DUT must ignore those itself
    always_comb begin
        bus.index_val = ireg[bus.idx_sel];
    end

    // Monitor: every cycle with DUT memory/strobe activity pops one entry
    always @(negedge clk) begin
        if (bus.mem_re | bus.mem_we | bus.ld_strobe | bus.st_strobe) begin
            if (bus.mem_re && !bus.mem_we && !bus.ld_strobe && !bus.st_strobe)
                m_kind = c_K_RE;
            else if (bus.mem_we && bus.st_strobe && !bus.mem_re && !bus.ld_strobe)
                m_kind = c_K_WE;
            else if (bus.ld_strobe && !bus.mem_re && !bus.mem_we && !bus.st_strobe)
                m_kind = c_K_LD;
            else
                m_kind = c_K_BAD;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: kind=%0d addr=0x%0h cyc=%0d, required no event",
                         m_kind, bus.mem_addr, cyc);
            end else begin
                m_exp = q.pop_front();
                if ((m_kind != m_exp.kind) || (32'(cyc) != m_exp.cyc) ||
                    ((m_kind != c_K_LD) && (bus.mem_addr != m_exp.addr))) begin
                    failures++;
                    $display("FAIL event: actual kind=%0d addr=0x%0h cyc=%0d, required kind=%0d addr=0x%0h cyc=%0d",
                             m_kind, bus.mem_addr, cyc, m_exp.kind, m_exp.addr, m_exp.cyc);
                end
            end
        end
    end

    function automatic logic [WORD_W-1:0] mk(input logic s, input logic [11:0] a,
                                             input logic [2:0] i, input logic [5:0] f,
                                             input logic [5:0] c);
        return {s, a, 3'b000, i, f, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [ADDR_W-1:0] a, input int c);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.cyc  = 32'(c);
        q.push_back(e);
    endtask

    // Raises start on a falling edge; the FETCH of start_pc is seen at cycle b
    task automatic begin_start(input logic [ADDR_W-1:0] a, output int b);
        @(negedge clk);
        start    = 1'b1;
        start_pc = a;
        b        = cyc + 1;
    endtask

    task automatic end_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int exp_cyc,
                             input logic [ADDR_W-1:0] exp_pc, input logic exp_fault);
        int n = 0;
        while (!halted && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halt_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_halted"}, 32'(halted), 32'd1);
        chk({name, "_pc"}, 32'(pc), 32'(exp_pc));
        chk({name, "_fault"}, 32'(fault), 32'(exp_fault));
        chk({name, "_queue"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        int b;
        logic [WORD_W-1:0] hlt;
        hlt = mk(1'b0, 12'd0, 3'd0, c_F_HLT, c_OP_HLT);
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) ireg[i] = 13'd0;
        ireg[0] = 13'd7;
        ireg[7] = 13'd9;
        reset    = 1'b0;
        start    = 1'b0;
        start_pc = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ctl", 32'({bus.mem_re, bus.mem_we, bus.ld_strobe, bus.st_strobe, halted, fault}), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_ir", 32'({bus.ir_c, bus.ir_f, bus.idx_sel}), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All-NOP memory from 0x010, HLT at 0x013
        mem[12'h013] = hlt;
        begin_start(12'h010, b);
        push(c_K_RE, 12'h010, b);
        push(c_K_RE, 12'h011, b + 3);
        push(c_K_RE, 12'h012, b + 6);
        push(c_K_RE, 12'h013, b + 9);
        end_start();
        wait_halt("nop", b + 12, 12'h013, 1'b0);

        // LDA A=100 I=0 at 0x000, restart from HALT
        mem[12'h000] = mk(1'b0, 12'd100, 3'd0, 6'd5, 6'd8);
        mem[12'h001] = hlt;
        begin_start(12'h000, b);
        push(c_K_RE, 12'h000, b);
        push(c_K_RE, 12'd100, b + 3);
        push(c_K_LD, 12'd0,   b + 4);
        push(c_K_RE, 12'h001, b + 5);
        end_start();
        wait_halt("lda", b + 8, 12'h001, 1'b0);

        // A=3 + I1=-5 gives EA=-2: fault without READ
        ireg[1] = {1'b1, 12'd5};
        mem[12'h040] = mk(1'b0, 12'd3, 3'd1, 6'd5, 6'd8);
        begin_start(12'h040, b);
        push(c_K_RE, 12'h040, b);
        end_start();
        wait_halt("ea_neg", b + 3, 12'h040, 1'b1);

        // JMP 0x7FF with I=7 (index ignored); start clears fault
        mem[12'h020] = mk(1'b0, 12'h7FF, 3'd7, c_F_JMP, c_OP_JMP);
        mem[12'h7FF] = hlt;
        begin_start(12'h020, b);
        push(c_K_RE, 12'h020, b);
        push(c_K_RE, 12'h7FF, b + 3);
        end_start();
        chk("jmp_fault_clr", 32'(fault), 32'd0);
        wait_halt("jmp", b + 6, 12'h7FF, 1'b0);

        // STA A=150 + I2=+50 -> EA 200
        ireg[2] = {1'b0, 12'd50};
        mem[12'h030] = mk(1'b0, 12'd150, 3'd2, 6'd5, 6'd24);
        mem[12'h031] = hlt;
        begin_start(12'h030, b);
        push(c_K_RE, 12'h030, b);
        push(c_K_RE, 12'd200, b + 3);
        push(c_K_WE, 12'd200, b + 4);
        push(c_K_RE, 12'h031, b + 5);
        end_start();
        wait_halt("sta", b + 8, 12'h031, 1'b0);

        // ADD A=-10 + I3=+20 -> EA 10; LDA A=-0 + I4=-0 -> EA 0
        ireg[3] = {1'b0, 12'd20};
        ireg[4] = {1'b1, 12'd0};
        mem[12'h050] = mk(1'b1, 12'd10, 3'd3, 6'd5, 6'd1);
        mem[12'h051] = mk(1'b1, 12'd0,  3'd4, 6'd5, 6'd8);
        mem[12'h052] = hlt;
        begin_start(12'h050, b);
        push(c_K_RE, 12'h050, b);
        push(c_K_RE, 12'd10,  b + 3);
        push(c_K_LD, 12'd0,   b + 4);
        push(c_K_RE, 12'h051, b + 5);
        push(c_K_RE, 12'd0,   b + 8);
        push(c_K_LD, 12'd0,   b + 9);
        push(c_K_RE, 12'h052, b + 10);
        end_start();
        wait_halt("add_mz", b + 13, 12'h052, 1'b0);

        // STA A=4095 + I5=+1 -> EA 4096 is out of range
        ireg[5] = {1'b0, 12'd1};
        mem[12'h060] = mk(1'b0, 12'd4095, 3'd5, 6'd5, 6'd24);
        begin_start(12'h060, b);
        push(c_K_RE, 12'h060, b);
        end_start();
        wait_halt("ea_4096", b + 3, 12'h060, 1'b1);

        // Undefined opcode C=2
        mem[12'h070] = mk(1'b0, 12'd0, 3'd0, 6'd0, 6'd2);
        begin_start(12'h070, b);
        push(c_K_RE, 12'h070, b);
        end_start();
        wait_halt("undef", b + 3, 12'h070, 1'b1);

        // Reset asserted during the WRITE cycle of a store
        mem[12'h080] = mk(1'b0, 12'd300, 3'd0, 6'd5, 6'd24);
        begin_start(12'h080, b);
        push(c_K_RE, 12'h080, b);
        push(c_K_RE, 12'd300, b + 3);
        push(c_K_WE, 12'd300, b + 4);
        end_start();
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_ctl", 32'({bus.mem_we, bus.st_strobe, bus.mem_re, bus.ld_strobe}), 32'd0);
        chk("rstmid_pc", 32'(pc), 32'd0);
        chk("rstmid_flags", 32'({halted, fault}), 32'd0);
        chk("rstmid_queue", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstmid_idle", 32'({halted, fault, pc}), 32'd0);

        // NOP at 4095 wraps pc to 0 (started from IDLE)
        mem[12'hFFF] = '0;
        mem[12'h000] = hlt;
        begin_start(12'hFFF, b);
        push(c_K_RE, 12'hFFF, b);
        push(c_K_RE, 12'h000, b + 3);
        end_start();
        wait_halt("wrap", b + 6, 12'h000, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_queue", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
